// File: rtl/path_recorder.sv
// path_recorder: snoops the timing analyser's node-delay table and records
// one reported critical path at a time. Each record is checked against the
// snooped delays, and its hops can be read back one by one while it is held.
module path_recorder (
  input  logic       clk,
  input  logic       rst,
  input  logic       sta_in_valid,
  input  logic [3:0] sta_delay,
  input  logic       in_valid,
  input  logic [7:0] worst_delay,
  input  logic [3:0] path,
  input  logic       rd_req,
  input  logic [3:0] rd_idx,
  output logic       done,
  output logic       rec_valid,
  output logic [4:0] hop_cnt,
  output logic [7:0] rec_delay,
  output logic [7:0] sum_delay,
  output logic [3:0] err,
  output logic       rd_valid,
  output logic [3:0] rd_node,
  output logic       rd_err
);

  typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

  state_t      state;
  logic [4:0]  snoop_cnt;
  logic [3:0]  dly      [16];
  logic [3:0]  path_buf [16];
  logic [15:0] visited;

  logic [15:0] node_bit;
  logic [7:0]  node_dly;
  logic [3:0]  last_idx;

  // Per-beat helpers: this node's mask bit, its snooped delay, and the slot of the last stored hop
  always_comb begin
    node_bit = 16'b1 << path;
    node_dly = {4'b0000, dly[path]};
    last_idx = hop_cnt[3:0] - 4'd1;
  end

  // Delay-table snoop: the k-th beat of each analyser input burst lands in dly[k]
  always_ff @(posedge clk) begin
    if (rst) begin
      snoop_cnt <= '0;
    end else if (sta_in_valid) begin
      if (snoop_cnt < 5'd16) begin
        dly[snoop_cnt[3:0]] <= sta_delay;
        snoop_cnt           <= snoop_cnt + 5'd1;
      end
    end else begin
      snoop_cnt <= '0;
    end
  end

  // Record FSM with its checks and the readback port; all outputs are registered
  always_ff @(posedge clk) begin
    done     <= 1'b0;
    rd_valid <= 1'b0;
    rd_node  <= '0;
    rd_err   <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      rec_valid <= 1'b0;
      hop_cnt   <= '0;
      rec_delay <= '0;
      sum_delay <= '0;
      err       <= '0;
      visited   <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (in_valid) begin
            // First beat opens a new record; a read requested on this edge is dropped
            state       <= CAPT;
            rec_valid   <= 1'b0;
            rec_delay   <= worst_delay;
            hop_cnt     <= 5'd1;
            path_buf[0] <= path;
            sum_delay   <= node_dly;
            visited     <= node_bit;
            err         <= {3'b000, (path != 4'd0)};
          end else if (state == HOLD && rd_req) begin
            rd_valid <= 1'b1;
            if ({1'b0, rd_idx} < hop_cnt) rd_node <= path_buf[rd_idx];
            else                          rd_err  <= 1'b1;
          end
        end
        CAPT: begin
          if (in_valid) begin
            if (hop_cnt < 5'd16) begin
              path_buf[hop_cnt[3:0]] <= path;
              hop_cnt                <= hop_cnt + 5'd1;
              sum_delay              <= sum_delay + node_dly;
              visited                <= visited | node_bit;
              if ((visited & node_bit) != '0) err[2] <= 1'b1;
            end else begin
              err[1] <= 1'b1;
            end
          end else begin
            state     <= HOLD;
            done      <= 1'b1;
            rec_valid <= 1'b1;
            err[3]    <= (sum_delay != rec_delay);
            if (path_buf[last_idx] != 4'd1) err[0] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
